gpu_mem_sequencer: RTL and testbench

//  Multi-phase Avalon-MM master for the render pipeline. Runs NUM_PHASES programmed phases in order; each phase reads or writes a contiguous element array.

---
 rtl/gpu_mem_sequencer_pkg.sv | 32 +++
 rtl/gpu_mem_sequencer_if.sv | 27 ++
 rtl/gpu_beat_fifo.sv | 50 +++++
 rtl/gpu_mem_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_gpu_mem_sequencer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_mem_sequencer_pkg.sv
// Shared types and helpers for the multi-phase GPU memory sequencer.
package gpu_mem_sequencer_pkg;

    localparam int unsigned ADDR_W = 32;

    typedef enum logic {
        PH_READ  = 1'b0,
        PH_WRITE = 1'b1
    } phase_dir_e;

    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_SETUP     = 3'd1,
        SEQ_READ      = 3'd2,
        SEQ_DRAIN     = 3'd3,
        SEQ_WRITE     = 3'd4,
        SEQ_NEXT      = 3'd5,
        SEQ_INTERRUPT = 3'd6
    } seq_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [31:0]       count;
        phase_dir_e        is_write;
    } phase_cfg_t;

    // Counter/index width that never collapses to zero bits.
    function automatic int unsigned min1_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpu_mem_sequencer_if.sv
// Avalon-MM master bus bundle used by the GPU memory sequencer.
interface gpu_mem_sequencer_if
    import gpu_mem_sequencer_pkg::*;
#(
    parameter int unsigned BUS_BYTES = 1
);
    localparam int unsigned BUS_W = BUS_BYTES * 8;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [BUS_W-1:0]  writedata;
    logic              waitrequest;
    logic [BUS_W-1:0]  readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/gpu_beat_fifo.sv
// Registered read-beat FIFO; push and pop may coincide at any occupancy.
module gpu_beat_fifo
    import gpu_mem_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned AW = min1_clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; pointers alone define validity.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/gpu_mem_sequencer.sv
// Multi-phase Avalon-MM master: streams element arrays in (read) or out (write) per phase.
// Optional GPU_SEQ_PERF_EN adds busy/stall cycle counters.
module gpu_mem_sequencer
    import gpu_mem_sequencer_pkg::*;
#(
    parameter int unsigned NUM_PHASES      = 3,
    parameter int unsigned BUS_BYTES       = 1,
    parameter int unsigned ELEM_BYTES      = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned PH_BITS         = min1_clog2(NUM_PHASES)
) (
    input  logic                             clock,
    input  logic                             reset,
    gpu_mem_sequencer_if.master              m1,
    input  logic [NUM_PHASES-1:0][31:0]      phase_base,
    input  logic [NUM_PHASES-1:0][31:0]      phase_count,
    input  logic [NUM_PHASES-1:0]            phase_is_write,
    input  logic                             start,
    input  logic                             clear_interrupt,
    output logic [ELEM_BYTES*8-1:0]          rd_data,
    output logic                             rd_valid,
    input  logic                             rd_ready,
    input  logic [ELEM_BYTES*8-1:0]          wr_data,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    output logic [31:0]                      elem_index,
    output logic [PH_BITS-1:0]               cur_phase,
    output logic                             busy,
    output logic                             irq
`ifdef GPU_SEQ_PERF_EN
    ,
    output logic [31:0]                      perf_busy_cycles,
    output logic [31:0]                      perf_stall_cycles
`endif
);
    localparam int unsigned BUS_W  = BUS_BYTES * 8;
    localparam int unsigned ELEM_W = ELEM_BYTES * 8;
    localparam int unsigned BEATS  = ELEM_BYTES / BUS_BYTES;
    localparam int unsigned BEAT_W = min1_clog2(BEATS);
    localparam int unsigned BCNT_W = 32 + min1_clog2(BEATS + 1);
    localparam int unsigned OCC_W  = $clog2(MAX_OUTSTANDING) + 1;

    localparam logic [2:0] ST_IDLE      = SEQ_IDLE;
    localparam logic [2:0] ST_SETUP     = SEQ_SETUP;
    localparam logic [2:0] ST_READ      = SEQ_READ;
    localparam logic [2:0] ST_DRAIN     = SEQ_DRAIN;
    localparam logic [2:0] ST_WRITE     = SEQ_WRITE;
    localparam logic [2:0] ST_NEXT      = SEQ_NEXT;
    localparam logic [2:0] ST_INTERRUPT = SEQ_INTERRUPT;

    logic [2:0]        state_q, state_d;
    phase_cfg_t        cfg_c;
    logic              last_phase_c;
    logic [31:0]       addr_q;
    logic              read_q, read_d;
    logic              write_q;
    logic [BUS_W-1:0]  wdata_q;
    logic [BCNT_W-1:0] beats_left_q, beats_left_d;
    logic [31:0]       elems_left_q;
    logic [OCC_W-1:0]  in_use_q, in_use_d;
    logic [OCC_W-1:0]  outst_q;
    logic [BEAT_W-1:0] wbeat_q;
    logic [BEAT_W-1:0] asm_cnt_q;
    logic [ELEM_W-1:0] asm_q;
    logic [ELEM_W-1:0] wbuf_q;
    logic              rd_acc_c, wr_acc_c, rd_hs_c, wr_hs_c;
    logic              push_c, pop_c, last_wbeat_c;
    logic [BUS_W-1:0]  fifo_rdata;
    logic [OCC_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty;

    assign cfg_c = '{base:     phase_base[cur_phase],
                     count:    phase_count[cur_phase],
                     is_write: phase_dir_e'(phase_is_write[cur_phase])};

    assign last_phase_c = (cur_phase == PH_BITS'(NUM_PHASES - 1));
    assign rd_acc_c     = read_q && !m1.waitrequest;
    assign wr_acc_c     = write_q && !m1.waitrequest;
    assign rd_hs_c      = rd_valid && rd_ready;
    assign wr_hs_c      = wr_ready && wr_valid;
    // Late beats arriving after a reset have no owner and are discarded.
    assign push_c       = m1.readdatavalid && (outst_q != '0);
    assign pop_c        = !fifo_empty && !rd_valid;
    assign last_wbeat_c = wr_acc_c && (wbeat_q == BEAT_W'(BEATS - 1));

    assign m1.address   = addr_q;
    assign m1.read      = read_q;
    assign m1.write     = write_q;
    assign m1.writedata = wdata_q;
    assign rd_data      = asm_q;

    gpu_beat_fifo #(
        .WIDTH (BUS_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_c),
        .push_data (m1.readdata),
        .pop       (pop_c),
        .pop_data  (fifo_rdata),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state plus the read-issue gate: in-flight + buffered beats never exceed MAX_OUTSTANDING.
    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = ST_SETUP;
            ST_SETUP: begin
                beats_left_d = BCNT_W'(cfg_c.count) * BCNT_W'(BEATS);
                if (cfg_c.count == '0)              state_d = ST_NEXT;
                else if (cfg_c.is_write == PH_WRITE) state_d = ST_WRITE;
                else                                state_d = ST_READ;
            end
            ST_READ: begin
                if (rd_acc_c) beats_left_d = beats_left_q - BCNT_W'(1);
                if (rd_acc_c && beats_left_q == BCNT_W'(1)) state_d = ST_DRAIN;
            end
            ST_DRAIN:     if (outst_q == '0 && fifo_count == '0 && !rd_valid && elems_left_q == '0)
                              state_d = ST_NEXT;
            ST_WRITE:     if (last_wbeat_c && elems_left_q == '0) state_d = ST_NEXT;
            ST_NEXT:      state_d = last_phase_c ? ST_INTERRUPT : ST_SETUP;
            ST_INTERRUPT: if (clear_interrupt) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        in_use_d = in_use_q + OCC_W'(rd_acc_c) - (rd_hs_c ? OCC_W'(BEATS) : OCC_W'(0));
        read_d   = (read_q && m1.waitrequest) ||
                   (state_d == ST_READ && beats_left_d != '0 &&
                    in_use_d < OCC_W'(MAX_OUTSTANDING) && !fifo_full);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_phase    <= '0;
            addr_q       <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            beats_left_q <= '0;
            elems_left_q <= '0;
            in_use_q     <= '0;
            outst_q      <= '0;
            wbeat_q      <= '0;
            asm_cnt_q    <= '0;
            asm_q        <= '0;
            wbuf_q       <= '0;
            rd_valid     <= 1'b0;
            wr_ready     <= 1'b0;
            elem_index   <= '0;
            busy         <= 1'b0;
            irq          <= 1'b0;
        end else begin
            read_q       <= read_d;
            beats_left_q <= beats_left_d;
            in_use_q     <= in_use_d;
            outst_q      <= outst_q + OCC_W'(rd_acc_c) - OCC_W'(push_c);
            busy         <= !(state_d == ST_IDLE || state_d == ST_INTERRUPT);
            irq          <= (state_d == ST_INTERRUPT);

            if (rd_acc_c || wr_acc_c) addr_q <= addr_q + 32'(BUS_BYTES);

            // Little-endian element assembly from the beat FIFO.
            if (pop_c) begin
                asm_q[32'(asm_cnt_q) * BUS_W +: BUS_W] <= fifo_rdata;
                if (asm_cnt_q == BEAT_W'(BEATS - 1)) begin
                    asm_cnt_q <= '0;
                    rd_valid  <= 1'b1;
                end else begin
                    asm_cnt_q <= asm_cnt_q + BEAT_W'(1);
                end
            end
            if (rd_hs_c) begin
                rd_valid     <= 1'b0;
                elem_index   <= elem_index + 32'd1;
                elems_left_q <= elems_left_q - 32'd1;
            end

            // Write element capture and beat serialisation.
            if (wr_hs_c) begin
                wbuf_q       <= wr_data;
                wdata_q      <= wr_data[BUS_W-1:0];
                write_q      <= 1'b1;
                wr_ready     <= 1'b0;
                wbeat_q      <= '0;
                elem_index   <= elem_index + 32'd1;
                elems_left_q <= elems_left_q - 32'd1;
            end
            if (wr_acc_c) begin
                if (last_wbeat_c) begin
                    write_q  <= 1'b0;
                    wr_ready <= (elems_left_q != '0);
                end else begin
                    wbeat_q <= wbeat_q + BEAT_W'(1);
                    wdata_q <= wbuf_q[(32'(wbeat_q) + 32'd1) * BUS_W +: BUS_W];
                end
            end

            case (state_q)
                ST_IDLE: if (start) cur_phase <= '0;
                ST_SETUP: begin
                    addr_q       <= cfg_c.base;
                    elems_left_q <= cfg_c.count;
                    elem_index   <= '0;
                    wbeat_q      <= '0;
                    wr_ready     <= (cfg_c.count != '0) && (cfg_c.is_write == PH_WRITE);
                end
                ST_NEXT: if (!last_phase_c) cur_phase <= cur_phase + PH_BITS'(1);
                default: ;
            endcase
        end
    end

`ifdef GPU_SEQ_PERF_EN
    // Saturating activity counters, cleared when a run is launched.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else if (state_q == ST_IDLE && start) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (busy && perf_busy_cycles != '1)
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            if ((read_q || write_q) && m1.waitrequest && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gpu_mem_sequencer.sv
// Directed bench for gpu_mem_sequencer with a byte-addressed Avalon slave model.
module tb_gpu_mem_sequencer;
    import gpu_mem_sequencer_pkg::*;

    localparam int unsigned NP = 3;
    localparam int unsigned BB = 1;
    localparam int unsigned EB = 2;
    localparam int unsigned MO = 4;
    localparam int unsigned PB = 2;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [NP-1:0][31:0]    phase_base;
    logic [NP-1:0][31:0]    phase_count;
    logic [NP-1:0]          phase_is_write;
    logic                   start, clear_interrupt;
    logic [EB*8-1:0]        rd_data;
    logic                   rd_valid, rd_ready;
    logic [EB*8-1:0]        wr_data;
    logic                   wr_valid, wr_ready;
    logic [31:0]            elem_index;
    logic [PB-1:0]          cur_phase;
    logic                   busy, irq;
`ifdef GPU_SEQ_PERF_EN
    logic [31:0]            perf_busy_cycles, perf_stall_cycles;
`endif

    gpu_mem_sequencer_if #(.BUS_BYTES(BB)) m1 ();

    gpu_mem_sequencer #(
        .NUM_PHASES(NP), .BUS_BYTES(BB), .ELEM_BYTES(EB), .MAX_OUTSTANDING(MO)
    ) dut (
        .clock(clock), .reset(reset), .m1(m1.master),
        .phase_base(phase_base), .phase_count(phase_count), .phase_is_write(phase_is_write),
        .start(start), .clear_interrupt(clear_interrupt),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .elem_index(elem_index), .cur_phase(cur_phase), .busy(busy), .irq(irq)
`ifdef GPU_SEQ_PERF_EN
        , .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    int unsigned    n_checks = 0;
    int unsigned    n_errors = 0;
    int unsigned    cyc = 0;
    bit             stall_rand = 0, rd_hold = 0, rd_rand = 0;
    int unsigned    lat_min = 1, lat_max = 1;
    int unsigned    n_rd_acc, n_wr_acc, n_rsp, ovl_err;
    logic [31:0]    first_addr, last_addr;
    logic [7:0]     wmem [logic [31:0]];
    logic [31:0]    rsp_addr [$];
    int unsigned    rsp_time [$];
    logic [15:0]    rx_data [$];
    logic [31:0]    rx_idx [$];
    logic [15:0]    wsrc [$];
    int unsigned    wptr;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (wmem.exists(a)) return wmem[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Slave, sink and source models; everything here is sampled by the DUT at the next posedge.
    always @(negedge clock) begin
        int unsigned t;
        cyc++;
        rd_ready = rd_hold ? 1'b0 : (rd_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        wr_valid = (wptr < wsrc.size());
        wr_data  = wr_valid ? wsrc[wptr] : 16'h0;
        if (reset) begin
            rsp_addr.delete();
            rsp_time.delete();
            m1.waitrequest   = 1'b0;
            m1.readdatavalid = 1'b0;
            m1.readdata      = '0;
        end else begin
            m1.waitrequest = stall_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (m1.read && !m1.waitrequest) begin
                if (n_rd_acc == 0) first_addr = m1.address;
                last_addr = m1.address;
                n_rd_acc++;
                if (phase_is_write[cur_phase] || m1.address < phase_base[cur_phase] ||
                    m1.address >= phase_base[cur_phase] + phase_count[cur_phase] * EB)
                    ovl_err++;
                t = cyc + lat_min + $urandom_range(0, lat_max - lat_min);
                if (rsp_time.size() > 0 && t < rsp_time[$]) t = rsp_time[$];
                rsp_addr.push_back(m1.address);
                rsp_time.push_back(t);
            end
            if (m1.write && !m1.waitrequest) begin
                if (!phase_is_write[cur_phase] || m1.address < phase_base[cur_phase] ||
                    m1.address >= phase_base[cur_phase] + phase_count[cur_phase] * EB)
                    ovl_err++;
                wmem[m1.address] = m1.writedata;
                n_wr_acc++;
            end
            if (rsp_time.size() > 0 && rsp_time[0] <= cyc) begin
                m1.readdatavalid = 1'b1;
                m1.readdata      = mem_rd(rsp_addr.pop_front());
                void'(rsp_time.pop_front());
                n_rsp++;
            end else begin
                m1.readdatavalid = 1'b0;
            end
        end
        if (rd_valid && rd_ready) begin
            rx_data.push_back(rd_data);
            rx_idx.push_back(elem_index);
        end
        if (wr_valid && wr_ready) wptr++;
    end

    task automatic set_phase(input int i, input logic [31:0] b, input logic [31:0] c, input logic w);
        phase_base[i]     = b;
        phase_count[i]    = c;
        phase_is_write[i] = w;
    endtask

    task automatic clear_log();
        n_rd_acc = 0; n_wr_acc = 0; n_rsp = 0; ovl_err = 0;
        first_addr = '0; last_addr = '0;
        rx_data.delete(); rx_idx.delete(); wsrc.delete(); wptr = 0;
    endtask

    task automatic start_run();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic wait_irq(input int unsigned budget, input string tag);
        int unsigned n = 0;
        while (!irq && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk_eq(tag, 64'(irq), 64'd1);
    endtask

    task automatic clear_irq(input string tag);
        @(negedge clock); clear_interrupt = 1'b1;
        @(negedge clock); clear_interrupt = 1'b0;
        #1;
        chk_eq({tag, "_irq_clr"}, 64'(irq), 64'd0);
    endtask

    task automatic check_reset_outs(input string tag);
        chk_eq({tag, "_read"},   64'(m1.read),    64'd0);
        chk_eq({tag, "_write"},  64'(m1.write),   64'd0);
        chk_eq({tag, "_rvalid"}, 64'(rd_valid),   64'd0);
        chk_eq({tag, "_wready"}, 64'(wr_ready),   64'd0);
        chk_eq({tag, "_irq"},    64'(irq),        64'd0);
        chk_eq({tag, "_busy"},   64'(busy),       64'd0);
        chk_eq({tag, "_addr"},   64'(m1.address), 64'd0);
        chk_eq({tag, "_eidx"},   64'(elem_index), 64'd0);
        chk_eq({tag, "_phase"},  64'(cur_phase),  64'd0);
    endtask

    task automatic check_rd(input string tag, input int first, input int n, input logic [31:0] base);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 32'(2 * i);
            chk_eq($sformatf("%s_d%0d", tag, i), 64'(rx_data[first + i]), 64'({mem_rd(a + 32'd1), mem_rd(a)}));
            chk_eq($sformatf("%s_i%0d", tag, i), 64'(rx_idx[first + i]), 64'(i));
        end
    endtask

    task automatic run_basic_read(input string tag);
        set_phase(0, 32'h50, 0, 1'b0);
        set_phase(1, 32'h100, 3, 1'b0);
        set_phase(2, 32'h80, 0, 1'b1);
        clear_log();
        start_run();
        wait_irq(300, {tag, "_irq"});
        chk_eq({tag, "_nrd"},   64'(n_rd_acc), 64'd6);
        chk_eq({tag, "_nwr"},   64'(n_wr_acc), 64'd0);
        chk_eq({tag, "_first"}, 64'(first_addr), 64'h100);
        chk_eq({tag, "_last"},  64'(last_addr), 64'h105);
        chk_eq({tag, "_nelem"}, 64'(rx_data.size()), 64'd3);
        if (rx_data.size() == 3) check_rd(tag, 0, 3, 32'h100);
        chk_eq({tag, "_busy"},  64'(busy), 64'd0);
    endtask

    initial begin
        int unsigned n;
        reset = 1'b1; start = 1'b0; clear_interrupt = 1'b0;
        phase_base = '0; phase_count = '0; phase_is_write = '0;
        clear_log();
        repeat (3) @(negedge clock);
        #1;
        check_reset_outs("rst");
        reset = 1'b0;

        // Single read phase between two empty phases; start is ignored while interrupting.
        run_basic_read("t1");
        start_run();
        repeat (3) @(negedge clock);
        chk_eq("t1_start_ign_irq", 64'(irq), 64'd1);
        chk_eq("t1_start_ign_busy", 64'(busy), 64'd0);
        chk_eq("t1_start_ign_nrd", 64'(n_rd_acc), 64'd6);
        clear_irq("t1");

        // Two-element write phase.
        set_phase(0, 32'h0, 0, 1'b0);
        set_phase(1, 32'h0, 0, 1'b1);
        set_phase(2, 32'h2000, 2, 1'b1);
        clear_log();
        wsrc.push_back(16'hBEEF);
        wsrc.push_back(16'h1234);
        start_run();
        wait_irq(300, "t2_irq");
        chk_eq("t2_nwr", 64'(n_wr_acc), 64'd4);
        chk_eq("t2_nrd", 64'(n_rd_acc), 64'd0);
        chk_eq("t2_b0", 64'(mem_rd(32'h2000)), 64'hEF);
        chk_eq("t2_b1", 64'(mem_rd(32'h2001)), 64'hBE);
        chk_eq("t2_b2", 64'(mem_rd(32'h2002)), 64'h34);
        chk_eq("t2_b3", 64'(mem_rd(32'h2003)), 64'h12);
        clear_irq("t2");

        // Sink backpressure: issue must stop at MAX_OUTSTANDING beats.
        set_phase(0, 32'h300, 5, 1'b0);
        set_phase(1, 32'h0, 0, 1'b0);
        set_phase(2, 32'h0, 0, 1'b0);
        clear_log();
        rd_hold = 1'b1;
        start_run();
        repeat (20) @(negedge clock);
        chk_eq("t3_nrd_held", 64'(n_rd_acc), 64'(MO));
        chk_eq("t3_rx_held", 64'(rx_data.size()), 64'd0);
        rd_hold = 1'b0;
        wait_irq(400, "t3_irq");
        chk_eq("t3_nelem", 64'(rx_data.size()), 64'd5);
        if (rx_data.size() == 5) check_rd("t3", 0, 5, 32'h300);
        clear_irq("t3");

        // Random stalls, latencies and sink readiness over three phases.
        stall_rand = 1'b1; rd_rand = 1'b1; lat_min = 1; lat_max = 4;
        set_phase(0, 32'h400, 5, 1'b0);
        set_phase(1, 32'h500, 7, 1'b0);
        set_phase(2, 32'h600, 4, 1'b1);
        clear_log();
        wsrc.push_back(16'hA1B2); wsrc.push_back(16'hC3D4);
        wsrc.push_back(16'h0F1E); wsrc.push_back(16'h7788);
        start_run();
        wait_irq(3000, "t4_irq");
        chk_eq("t4_nelem", 64'(rx_data.size()), 64'd12);
        if (rx_data.size() == 12) begin
            check_rd("t4p0", 0, 5, 32'h400);
            check_rd("t4p1", 5, 7, 32'h500);
        end
        chk_eq("t4_nwr", 64'(n_wr_acc), 64'd8);
        chk_eq("t4_w0", 64'({mem_rd(32'h601), mem_rd(32'h600)}), 64'hA1B2);
        chk_eq("t4_w1", 64'({mem_rd(32'h603), mem_rd(32'h602)}), 64'hC3D4);
        chk_eq("t4_w2", 64'({mem_rd(32'h605), mem_rd(32'h604)}), 64'h0F1E);
        chk_eq("t4_w3", 64'({mem_rd(32'h607), mem_rd(32'h606)}), 64'h7788);
        chk_eq("t4_overlap", 64'(ovl_err), 64'd0);
        clear_irq("t4");
        stall_rand = 1'b0; rd_rand = 1'b0;

        // Reset with reads in flight, then a fresh run.
        lat_min = 12; lat_max = 12;
        set_phase(0, 32'h700, 5, 1'b0);
        set_phase(1, 32'h0, 0, 1'b0);
        set_phase(2, 32'h0, 0, 1'b0);
        clear_log();
        start_run();
        n = 0;
        while (n_rd_acc < 4 && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk_eq("t5_inflight", 64'(n_rd_acc), 64'd4);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check_reset_outs("t5");
        reset = 1'b0;
        lat_min = 1; lat_max = 1;
        @(negedge clock);
        run_basic_read("t5r");
        clear_irq("t5r");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
